call_stack_halt: RTL and testbench
==================================

# call_stack_halt

Return-address stack and halt controller for the 32-bit RISC datapath. It pushes return addresses on CALL, pops them on RET and reports stack occupancy. It also sequences processor shutdown on HALT or a stack fault. It drives `stopSignal` and `isStackEmpty`, the pair the datapath bench samples on the falling edge of `sysClk` to end simulation: a clean program run ends with both high.

## Interface
- `DEPTH`, 8: number of stack entries, 2..64.
- `AW`, 32: return-address width.
- `DRAIN_MAX`, 16: maximum number of DRAIN cycles before a forced stop, 1..255.

- `sysClk` in 1: the single clock. Everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pushEn` in 1: CALL retiring. Push `pushAddr`.
- `pushAddr` in AW: return address to push.
- `popEn` in 1: RET retiring. Pop the top entry.
- `topAddr` out AW: current top of stack, combinational from the array. Equals 0 when empty.
- `haltReq` in 1: HALT instruction decoded, one-cycle pulse or level.
- `pipeIdle` in 1: pipeline holds no in-flight instructions.
- `isStackEmpty` out 1: occupancy is 0.
- `isStackFull` out 1: occupancy is DEPTH.
- `stopSignal` out 1: processor stopped. Registered.
- `errCode` out 2: sticky cause of the stop. 0 = none/clean, 1 = overflow, 2 = underflow, 3 = drain timeout. Registered.

## Operation
- Storage: `DEPTH` x `AW` register array.
- Occupancy counter `sp` has width clog2(DEPTH+1). It is 0 on reset. Array contents are not reset.
- `topAddr` = array[sp-1] when sp>0, else 0.
- Stack ops are accepted only in RUN and DRAIN. In STOPPED, `pushEn` and `popEn` are ignored and `sp` is frozen.
- Push only, sp<DEPTH: array[sp] <= pushAddr, sp+1.
- Pop only, sp>0: sp-1.
- Push and pop together, sp>0: array[sp-1] <= pushAddr, sp unchanged (replace top). This is also legal at sp=DEPTH.
- Push only at sp=DEPTH: overflow. The write is dropped and sp is unchanged. Go to STOPPED with errCode=1.
- Pop at sp=0, with or without a push: underflow. Nothing is written and sp is unchanged. Go to STOPPED with errCode=2.
- FSM states are RUN, DRAIN and STOPPED. Reset puts it in RUN.
- RUN:
  - A fault takes priority: go to STOPPED.
  - Otherwise haltReq=1 goes to DRAIN and clears the drain counter.
- DRAIN:
  - A fault goes to STOPPED with its errCode.
  - Otherwise pipeIdle=1 goes to STOPPED with errCode=0.
  - Otherwise, once the drain counter reaches DRAIN_MAX-1, go to STOPPED with errCode=3.
  - Otherwise increment the counter.
  - haltReq is ignored in this state.
- STOPPED: absorbing. The only exit is `reset`, which returns to RUN with sp=0, errCode=0 and stopSignal=0.
- When a fault and haltReq occur in the same RUN cycle, the fault wins.

## Timing
- Reset values: stopSignal=0, errCode=0, isStackEmpty=1, isStackFull=0, topAddr=0.
- `isStackEmpty` and `isStackFull` decode the registered `sp`. They update in the cycle after the edge that changes sp.
- Push to topAddr latency is 1 edge: after the push edge, topAddr = pushAddr.
- Clean halt: haltReq is sampled at edge N. If pipeIdle=1 at edge N+1, stopSignal=1 after edge N+1 (2 edges of latency).
- Timeout: if pipeIdle stays 0, stopSignal=1 after edge N+DRAIN_MAX with errCode=3.
- Fault: a fault sampled at edge N gives stopSignal=1 and errCode valid after edge N.
- stopSignal is stable between rising edges, so falling-edge sampling is safe.
- Reset asserted in any state, including mid-DRAIN, takes effect at the next edge and overrides every other input.

## Structure
- Shared package `risc_pkg` holds:
  - the state enum `halt_state_t` {RUN, DRAIN, STOPPED};
  - `err_code_t` constants ERR_NONE, ERR_OVF, ERR_UDF, ERR_TMO;
  - the default `AW`.
- One sub-module, `ras_lifo`: the array, `sp`, the push/pop/replace rules and the empty/full decode. It exposes `ovf` and `udf` strobes.
- The top level holds the FSM, drain counter, stopSignal and errCode registers.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Nested calls then a clean halt:
  - Stimulus: push 0x100, 0x200, 0x300, then pop three times (topAddr reads 0x300, 0x200, 0x100), then haltReq with pipeIdle=1.
  - Required: isStackEmpty=1, then stopSignal=1 two edges after haltReq, errCode=0.
- Overflow:
  - Stimulus (DEPTH=8): 8 pushes of 0x10..0x80 set isStackFull=1. Then a 9th push of 0x90.
  - Required: stopSignal=1 with errCode=1, topAddr=0x80, and later pushes and pops are ignored.
- Underflow:
  - Stimulus: pop at reset, or pop together with a push of 0x44 on an empty stack.
  - Required: stopSignal=1, errCode=2, isStackEmpty=1.
- Replace on full:
  - Stimulus: fill to 8 entries, then push 0xAA and pop together.
  - Required: sp stays 8, topAddr=0xAA, no fault. Eight pops then drain the stack cleanly.
- Drain timeout and drain fault:
  - Timeout stimulus (DRAIN_MAX=4): haltReq with pipeIdle held 0.
  - Timeout required: stopSignal=1 four edges after DRAIN entry, errCode=3.
  - Fault stimulus: a pop on an empty stack during DRAIN.
  - Fault required: errCode=2.
- Reset mid-operation:
  - Stimulus: 3 pushes, haltReq, then reset in the DRAIN state.
  - Required: after the reset edge, sp=0, isStackEmpty=1, stopSignal=0, errCode=0, state RUN. A following push of 0x55 gives topAddr=0x55.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared types and defaults for the return-address stack and halt controller
package risc_pkg;
  localparam int DEFAULT_AW = 32;
  typedef enum logic [1:0] {RUN, DRAIN, STOPPED} halt_state_t;
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_t;
endpackage

// File: rtl/ras_lifo.sv
// ras_lifo: return-address LIFO with push/pop/replace rules and overflow/underflow strobes
// Ports: clk, rst (sync, active high); en gates all ops; push/pop/push_addr request;
//        top = entry below sp (0 when empty); empty/full decode sp; ovf/udf flag rejected ops.
module ras_lifo #(
  parameter int DEPTH = 8,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp, tp;
  logic wr_rep, wr_new, dec;
  always_comb begin
    tp = sp - SW'(1);
    empty = sp == '0;
    full = sp == SW'(DEPTH);
    ovf = en & push & ~pop & full;
    udf = en & pop & empty;
    wr_rep = en & push & pop & ~empty;
    wr_new = en & push & ~pop & ~full;
    dec = en & pop & ~push & ~empty;
    top = empty ? '0 : mem[tp[IW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) sp <= '0;
    else if (wr_new) sp <= sp + SW'(1);
    else if (dec) sp <= tp;
  end
  // contents are deliberately not reset; sp alone defines what is valid
  always_ff @(posedge clk) begin
    if (wr_rep) mem[tp[IW-1:0]] <= push_addr;
    else if (wr_new) mem[sp[IW-1:0]] <= push_addr;
  end
endmodule

// File: rtl/call_stack_halt.sv
// call_stack_halt: return-address stack plus RUN/DRAIN/STOPPED shutdown sequencer
// Ports: sysClk, reset (sync, active high); pushEn/pushAddr/popEn stack ops; topAddr top entry;
//        haltReq, pipeIdle drain control; isStackEmpty/isStackFull occupancy;
//        stopSignal registered stop flag; errCode sticky stop cause.
module call_stack_halt import risc_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = DEFAULT_AW,
  parameter int DRAIN_MAX = 16
) (
  input  logic          sysClk,
  input  logic          reset,
  input  logic          pushEn,
  input  logic [AW-1:0] pushAddr,
  input  logic          popEn,
  output logic [AW-1:0] topAddr,
  input  logic          haltReq,
  input  logic          pipeIdle,
  output logic          isStackEmpty,
  output logic          isStackFull,
  output logic          stopSignal,
  output logic [1:0]    errCode
);
  halt_state_t state, state_n;
  err_code_t err, err_n;
  logic [7:0] cnt, cnt_n;
  logic ovf, udf, ops_en;
  assign ops_en = state != STOPPED;
  assign errCode = err;
  ras_lifo #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
    .clk(sysClk),
    .rst(reset),
    .en(ops_en),
    .push(pushEn),
    .pop(popEn),
    .push_addr(pushAddr),
    .top(topAddr),
    .empty(isStackEmpty),
    .full(isStackFull),
    .ovf(ovf),
    .udf(udf)
  );
  always_comb begin
    state_n = state;
    err_n = err;
    cnt_n = cnt;
    case (state)
      RUN: begin
        if (ovf || udf) begin
          state_n = STOPPED;
          err_n = ovf ? ERR_OVF : ERR_UDF;
        end else if (haltReq) begin
          state_n = DRAIN;
          cnt_n = '0;
        end
      end
      DRAIN: begin
        if (ovf || udf) begin
          state_n = STOPPED;
          err_n = ovf ? ERR_OVF : ERR_UDF;
        end else if (pipeIdle) begin
          state_n = STOPPED;
          err_n = ERR_NONE;
        end else if (cnt == 8'(DRAIN_MAX - 1)) begin
          state_n = STOPPED;
          err_n = ERR_TMO;
        end else cnt_n = cnt + 8'd1;
      end
      default: state_n = state;
    endcase
  end
  // stopSignal is its own flop so it only moves on rising edges
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state <= RUN;
      err <= ERR_NONE;
      cnt <= '0;
      stopSignal <= 1'b0;
    end else begin
      state <= state_n;
      err <= err_n;
      cnt <= cnt_n;
      stopSignal <= state_n == STOPPED;
    end
  end
endmodule

// File: tb/tb_call_stack_halt.sv
// tb_call_stack_halt: vector table, corner sequences and random run against a queue-based model
module tb_call_stack_halt;
  localparam int DEPTH = 8;
  localparam int DMAX = 4;
  logic sysClk, reset, pushEn, popEn, haltReq, pipeIdle;
  logic [31:0] pushAddr, topAddr;
  logic isStackEmpty, isStackFull, stopSignal;
  logic [1:0] errCode;
  int checks = 0;
  int errors = 0;

  call_stack_halt #(.DEPTH(DEPTH), .AW(32), .DRAIN_MAX(DMAX)) dut (
    .sysClk(sysClk), .reset(reset), .pushEn(pushEn), .pushAddr(pushAddr), .popEn(popEn),
    .topAddr(topAddr), .haltReq(haltReq), .pipeIdle(pipeIdle), .isStackEmpty(isStackEmpty),
    .isStackFull(isStackFull), .stopSignal(stopSignal), .errCode(errCode)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic [31:0] stk[$];
  bit m_stop, m_drain;
  int m_age, m_err;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, pu, po, input logic [31:0] a, input bit h, id);
    int f;
    if (r) begin
      stk.delete();
      m_stop = 0;
      m_drain = 0;
      m_age = 0;
      m_err = 0;
    end else if (!m_stop) begin
      f = 0;
      if (po && stk.size() == 0) f = 2;
      else if (pu && !po && stk.size() == DEPTH) f = 1;
      else if (pu && po) stk[stk.size()-1] = a;
      else if (po) void'(stk.pop_back());
      else if (pu) stk.push_back(a);
      if (f != 0) begin
        m_stop = 1;
        m_err = f;
      end else if (m_drain) begin
        if (id) begin
          m_stop = 1;
          m_err = 0;
        end else if (m_age == DMAX - 1) begin
          m_stop = 1;
          m_err = 3;
        end else m_age++;
      end else if (h) begin
        m_drain = 1;
        m_age = 0;
      end
    end
  endtask

  task automatic step(input bit r, pu, po, input logic [31:0] a, input bit h, id);
    reset = r;
    pushEn = pu;
    popEn = po;
    pushAddr = a;
    haltReq = h;
    pipeIdle = id;
    @(posedge sysClk);
    model(r, pu, po, a, h, id);
    @(negedge sysClk);
    chk("m_top", topAddr, stk.size() != 0 ? stk[stk.size()-1] : 32'h0);
    chk("m_empty", {31'b0, isStackEmpty}, {31'b0, stk.size() == 0});
    chk("m_full", {31'b0, isStackFull}, {31'b0, stk.size() == DEPTH});
    chk("m_stop", {31'b0, stopSignal}, {31'b0, m_stop});
    chk("m_err", {30'b0, errCode}, m_err);
  endtask

  typedef struct {
    bit r, pu, po;
    logic [31:0] a;
    bit h, id;
    logic [31:0] top;
    bit e, s;
    logic [1:0] err;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit r, pu, po, input logic [31:0] a, input bit h, id,
                     input logic [31:0] top, input bit e, s, input logic [1:0] err);
    vec_t v;
    v.r = r; v.pu = pu; v.po = po; v.a = a; v.h = h; v.id = id;
    v.top = top; v.e = e; v.s = s; v.err = err;
    tv.push_back(v);
  endtask

  initial begin
    reset = 1'b1; pushEn = 1'b0; popEn = 1'b0; pushAddr = '0; haltReq = 1'b0; pipeIdle = 1'b0;
    add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 2'd0);
    add(1'b0, 1'b1, 1'b0, 32'h77,  1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 2'd2);
    add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 2'd2);
    add(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd0);
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].pu, tv[i].po, tv[i].a, tv[i].h, tv[i].id);
      chk($sformatf("v%0d_top", i), topAddr, tv[i].top);
      chk($sformatf("v%0d_empty", i), {31'b0, isStackEmpty}, {31'b0, tv[i].e});
      chk($sformatf("v%0d_stop", i), {31'b0, stopSignal}, {31'b0, tv[i].s});
      chk($sformatf("v%0d_err", i), {30'b0, errCode}, {30'b0, tv[i].err});
    end

    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 32'(i * 16), 0, 0);
    chk("ovf_full", {31'b0, isStackFull}, 32'd1);
    step(0, 1, 0, 32'h90, 0, 0);
    chk("ovf_stop", {31'b0, stopSignal}, 32'd1);
    chk("ovf_err", {30'b0, errCode}, 32'd1);
    chk("ovf_top", topAddr, 32'h80);
    step(0, 0, 1, 32'h0, 0, 0);
    step(0, 1, 0, 32'hA0, 0, 0);
    chk("ovf_frozen", topAddr, 32'h80);

    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 32'(i * 16), 0, 0);
    step(0, 1, 1, 32'hAA, 0, 0);
    chk("rep_top", topAddr, 32'hAA);
    chk("rep_full", {31'b0, isStackFull}, 32'd1);
    chk("rep_stop", {31'b0, stopSignal}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h0, 0, 0);
    chk("rep_empty", {31'b0, isStackEmpty}, 32'd1);
    chk("rep_clean", {30'b0, errCode, stopSignal}, 32'd0);

    step(1, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    for (int i = 1; i < DMAX; i++) begin
      step(0, 0, 0, 32'h0, 0, 0);
      chk("tmo_wait", {31'b0, stopSignal}, 32'd0);
    end
    step(0, 0, 0, 32'h0, 0, 0);
    chk("tmo_stop", {31'b0, stopSignal}, 32'd1);
    chk("tmo_err", {30'b0, errCode}, 32'd3);

    step(1, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 1, 32'h0, 0, 0);
    chk("dfault_err", {30'b0, errCode}, 32'd2);

    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 32'(i), 0, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0);
    chk("rst_empty", {31'b0, isStackEmpty}, 32'd1);
    chk("rst_clean", {30'b0, errCode, stopSignal}, 32'd0);
    step(0, 1, 0, 32'h55, 0, 0);
    chk("rst_push", topAddr, 32'h55);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1);
    chk("rst_run_halt", {31'b0, stopSignal}, 32'd1);

    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0) || (m_stop && $urandom_range(0, 5) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom,
           $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
